// File: rtl/issue_queue.sv
// In-order issue stage: a DEPTH-entry circular buffer between decode and the
// functional units, with a pending-write scoreboard that blocks RAW/WAW hazards.
module issue_queue #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_UNITS = 3,
    parameter int UNIT_W    = 2,
    parameter int CTRL_W    = 48
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       id_iq_valid,
    output logic                       iq_id_ready,
    input  logic [REG_AW-1:0]          id_iq_addra,
    input  logic [REG_AW-1:0]          id_iq_addrb,
    input  logic                       id_iq_checka,
    input  logic                       id_iq_checkb,
    input  logic [REG_AW-1:0]          id_iq_regdest,
    input  logic                       id_iq_writereg,
    input  logic [UNIT_W-1:0]          id_iq_unit,
    input  logic [CTRL_W-1:0]          id_iq_ctrl,
    output logic [REG_AW-1:0]          iq_reg_addra,
    output logic [REG_AW-1:0]          iq_reg_addrb,
    input  logic [DATA_W-1:0]          reg_iq_dataa,
    input  logic [DATA_W-1:0]          reg_iq_datab,
    input  logic [NUM_UNITS-1:0]       ex_iq_busy,
    input  logic                       wb_iq_valid,
    input  logic [REG_AW-1:0]          wb_iq_addr,
    input  logic                       flush,
    output logic                       iq_ex_valid,
    output logic [UNIT_W-1:0]          iq_ex_unit,
    output logic [CTRL_W-1:0]          iq_ex_ctrl,
    output logic [DATA_W-1:0]          iq_ex_rega,
    output logic [DATA_W-1:0]          iq_ex_regb,
    output logic [REG_AW-1:0]          iq_ex_regdest,
    output logic                       iq_ex_writereg,
    output logic [$clog2(DEPTH):0]     iq_count,
    output logic                       iq_err_unit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] addra;
        logic [REG_AW-1:0] addrb;
        logic              checka;
        logic              checkb;
        logic [REG_AW-1:0] regdest;
        logic              writereg;
        logic [UNIT_W-1:0] unit;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            head;
    entry_t            wr_entry;
    logic              wr_en;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              err_unit_q, err_unit_d;

    logic              ex_valid_q, ex_valid_d;
    logic [UNIT_W-1:0] ex_unit_q, ex_unit_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_rega_q, ex_rega_d;
    logic [DATA_W-1:0] ex_regb_q, ex_regb_d;
    logic [REG_AW-1:0] ex_regdest_q, ex_regdest_d;
    logic              ex_writereg_q, ex_writereg_d;

    logic              has_head, unit_ok, unit_busy, operands_clear;
    logic              dispatch, drop, pop, enq;

    assign head         = mem_q[head_q];
    assign iq_id_ready  = (count_q < DEPTH_C);
    assign iq_reg_addra = head.addra;
    assign iq_reg_addrb = head.addrb;

    // Hazard checks read only the registered scoreboard, so a writeback is
    // visible to the head one cycle after it lands.
    always_comb begin
        has_head  = (count_q != '0);
        unit_ok   = (int'(head.unit) < NUM_UNITS);
        unit_busy = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (int'(head.unit) == u) begin
                unit_busy = ex_iq_busy[u];
            end
        end
        operands_clear = !(head.checka && pending_q[head.addra])
                      && !(head.checkb && pending_q[head.addrb])
                      && !(head.writereg && pending_q[head.regdest]);
        dispatch = has_head && unit_ok && !unit_busy && operands_clear && !flush;
        drop     = has_head && !unit_ok && !flush;
        pop      = dispatch || drop;
        enq      = id_iq_valid && iq_id_ready && !flush;
    end

    always_comb begin
        wr_en             = enq;
        wr_entry.addra    = id_iq_addra;
        wr_entry.addrb    = id_iq_addrb;
        wr_entry.checka   = id_iq_checka;
        wr_entry.checkb   = id_iq_checkb;
        wr_entry.regdest  = id_iq_regdest;
        wr_entry.writereg = id_iq_writereg;
        wr_entry.unit     = id_iq_unit;
        wr_entry.ctrl     = id_iq_ctrl;
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pending_d     = pending_q;
        err_unit_d    = err_unit_q | drop;
        ex_valid_d    = dispatch;
        ex_unit_d     = ex_unit_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_rega_d     = ex_rega_q;
        ex_regb_d     = ex_regb_q;
        ex_regdest_d  = ex_regdest_q;
        ex_writereg_d = ex_writereg_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (pop) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end

        // Clear first, then set: a dispatching writer beats a same-cycle writeback.
        if (wb_iq_valid) pending_d[wb_iq_addr] = 1'b0;
        if (dispatch && head.writereg) pending_d[head.regdest] = 1'b1;
        pending_d[0] = 1'b0;

        if (dispatch) begin
            ex_unit_d     = head.unit;
            ex_ctrl_d     = head.ctrl;
            ex_rega_d     = reg_iq_dataa;
            ex_regb_d     = reg_iq_datab;
            ex_regdest_d  = head.regdest;
            ex_writereg_d = head.writereg;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[tail_q] <= wr_entry;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            pending_q     <= '0;
            err_unit_q    <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_unit_q     <= '0;
            ex_ctrl_q     <= '0;
            ex_rega_q     <= '0;
            ex_regb_q     <= '0;
            ex_regdest_q  <= '0;
            ex_writereg_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            err_unit_q    <= err_unit_d;
            ex_valid_q    <= ex_valid_d;
            ex_unit_q     <= ex_unit_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rega_q     <= ex_rega_d;
            ex_regb_q     <= ex_regb_d;
            ex_regdest_q  <= ex_regdest_d;
            ex_writereg_q <= ex_writereg_d;
        end
    end

    assign iq_ex_valid    = ex_valid_q;
    assign iq_ex_unit     = ex_unit_q;
    assign iq_ex_ctrl     = ex_ctrl_q;
    assign iq_ex_rega     = ex_rega_q;
    assign iq_ex_regb     = ex_regb_q;
    assign iq_ex_regdest  = ex_regdest_q;
    assign iq_ex_writereg = ex_writereg_q;
    assign iq_count       = count_q;
    assign iq_err_unit    = err_unit_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected dispatches are queued as instructions
// are enqueued and compared field by field when iq_ex_valid pulses.
module tb_issue_queue;

    logic        clock;
    logic        reset;
    logic        id_iq_valid;
    logic        iq_id_ready;
    logic [4:0]  id_iq_addra, id_iq_addrb, id_iq_regdest;
    logic        id_iq_checka, id_iq_checkb, id_iq_writereg;
    logic [1:0]  id_iq_unit;
    logic [47:0] id_iq_ctrl;
    logic [4:0]  iq_reg_addra, iq_reg_addrb;
    logic [31:0] reg_iq_dataa, reg_iq_datab;
    logic [2:0]  ex_iq_busy;
    logic        wb_iq_valid;
    logic [4:0]  wb_iq_addr;
    logic        flush;
    logic        iq_ex_valid;
    logic [1:0]  iq_ex_unit;
    logic [47:0] iq_ex_ctrl;
    logic [31:0] iq_ex_rega, iq_ex_regb;
    logic [4:0]  iq_ex_regdest;
    logic        iq_ex_writereg;
    logic [2:0]  iq_count;
    logic        iq_err_unit;

    logic [31:0] arf [32];

    typedef struct {
        logic [1:0]  unit;
        logic [47:0] ctrl;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [4:0]  regdest;
        logic        writereg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    issue_queue dut (
        .clock(clock), .reset(reset),
        .id_iq_valid(id_iq_valid), .iq_id_ready(iq_id_ready),
        .id_iq_addra(id_iq_addra), .id_iq_addrb(id_iq_addrb),
        .id_iq_checka(id_iq_checka), .id_iq_checkb(id_iq_checkb),
        .id_iq_regdest(id_iq_regdest), .id_iq_writereg(id_iq_writereg),
        .id_iq_unit(id_iq_unit), .id_iq_ctrl(id_iq_ctrl),
        .iq_reg_addra(iq_reg_addra), .iq_reg_addrb(iq_reg_addrb),
        .reg_iq_dataa(reg_iq_dataa), .reg_iq_datab(reg_iq_datab),
        .ex_iq_busy(ex_iq_busy),
        .wb_iq_valid(wb_iq_valid), .wb_iq_addr(wb_iq_addr),
        .flush(flush),
        .iq_ex_valid(iq_ex_valid), .iq_ex_unit(iq_ex_unit), .iq_ex_ctrl(iq_ex_ctrl),
        .iq_ex_rega(iq_ex_rega), .iq_ex_regb(iq_ex_regb),
        .iq_ex_regdest(iq_ex_regdest), .iq_ex_writereg(iq_ex_writereg),
        .iq_count(iq_count), .iq_err_unit(iq_err_unit)
    );

    assign reg_iq_dataa = arf[iq_reg_addra];
    assign reg_iq_datab = arf[iq_reg_addrb];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (iq_ex_valid) begin
            check("dispatch_expected", 64'(sb.size() == 0), 64'(0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ex_unit",     64'(iq_ex_unit),     64'(e.unit));
                check("ex_ctrl",     64'(iq_ex_ctrl),     64'(e.ctrl));
                check("ex_rega",     64'(iq_ex_rega),     64'(e.rega));
                check("ex_regb",     64'(iq_ex_regb),     64'(e.regb));
                check("ex_regdest",  64'(iq_ex_regdest),  64'(e.regdest));
                check("ex_writereg", 64'(iq_ex_writereg), 64'(e.writereg));
                $display("dispatch unit=%0d ctrl=%h rega=%h regb=%h rd=%0d wr=%0d",
                         iq_ex_unit, iq_ex_ctrl, iq_ex_rega, iq_ex_regb, iq_ex_regdest, iq_ex_writereg);
            end
        end
    endtask

    task automatic enq(input logic [4:0] a, input logic [4:0] b, input logic ca, input logic cb,
                       input logic [4:0] rd, input logic wr, input logic [1:0] u,
                       input logic [47:0] c, input logic push);
        exp_t e;
        id_iq_addra = a;  id_iq_addrb = b;
        id_iq_checka = ca; id_iq_checkb = cb;
        id_iq_regdest = rd; id_iq_writereg = wr;
        id_iq_unit = u; id_iq_ctrl = c;
        id_iq_valid = 1'b1;
        check("enq_ready", 64'(iq_id_ready), 64'(1));
        e.unit = u; e.ctrl = c; e.rega = arf[a]; e.regb = arf[b];
        e.regdest = rd; e.writereg = wr;
        tick();
        id_iq_valid = 1'b0;
        if (push) sb.push_back(e);
    endtask

    task automatic wb(input logic [4:0] r);
        wb_iq_valid = 1'b1;
        wb_iq_addr  = r;
        tick();
        wb_iq_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) arf[i] = (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);
        reset = 1'b0;
        id_iq_valid = 1'b0; id_iq_addra = '0; id_iq_addrb = '0;
        id_iq_checka = 1'b0; id_iq_checkb = 1'b0; id_iq_regdest = '0;
        id_iq_writereg = 1'b0; id_iq_unit = '0; id_iq_ctrl = '0;
        ex_iq_busy = '0; wb_iq_valid = 1'b0; wb_iq_addr = '0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Reset state
        check("rst_ready",    64'(iq_id_ready),    64'(1));
        check("rst_count",    64'(iq_count),       64'(0));
        check("rst_valid",    64'(iq_ex_valid),    64'(0));
        check("rst_writereg", 64'(iq_ex_writereg), 64'(0));
        check("rst_rega",     64'(iq_ex_rega),     64'(0));
        check("rst_err",      64'(iq_err_unit),    64'(0));

        // Fill with unit 0 stalled, then drain in program order
        ex_iq_busy = 3'b001;
        for (int i = 0; i < 4; i++)
            enq(5'd1, 5'd2, 1'b1, 1'b1, 5'(10 + i), 1'b1, 2'd0, 48'h0000_0000_ADD0 + 48'(i), 1'b1);
        check("full_count", 64'(iq_count),    64'(4));
        check("full_ready", 64'(iq_id_ready), 64'(0));
        id_iq_valid = 1'b1;
        tick();
        id_iq_valid = 1'b0;
        check("full_no_accept", 64'(iq_count), 64'(4));
        ex_iq_busy = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_valid", 64'(iq_ex_valid), 64'(1));
        end
        check("drain_count", 64'(iq_count), 64'(0));
        for (int i = 0; i < 4; i++) wb(5'(10 + i));

        // RAW: ADD r4,r3,r1 waits for MUL r3 writeback
        enq(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'd1, 48'h0000_0000_0E11, 1'b1);
        enq(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 2'd0, 48'h0000_0000_0ADD, 1'b1);
        e = sb.pop_back();
        e.rega = 32'h1234;
        sb.push_back(e);
        tick();
        check("raw_hold_valid", 64'(iq_ex_valid), 64'(0));
        check("raw_hold_count", 64'(iq_count),    64'(1));
        tick();
        check("raw_hold_valid2", 64'(iq_ex_valid), 64'(0));
        arf[3] = 32'h1234;
        wb(5'd3);
        check("raw_wb_cycle", 64'(iq_ex_valid), 64'(0));
        tick();
        check("raw_dispatch", 64'(iq_ex_valid), 64'(1));
        wb(5'd4);

        // WAW and set-wins on r5
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 48'h0000_0000_0501, 1'b1);
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 48'h0000_0000_0502, 1'b1);
        tick();
        check("waw_hold", 64'(iq_ex_valid), 64'(0));
        wb_iq_valid = 1'b1;
        wb_iq_addr  = 5'd5;
        tick();
        check("waw_wb1", 64'(iq_ex_valid), 64'(0));
        tick();
        check("waw_dispatch_with_wb", 64'(iq_ex_valid), 64'(1));
        wb_iq_valid = 1'b0;
        enq(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 2'd0, 48'h0000_0000_0503, 1'b1);
        tick();
        check("setwins_reader_hold",  64'(iq_ex_valid), 64'(0));
        check("setwins_reader_count", 64'(iq_count),    64'(1));
        wb(5'd5);
        tick();
        check("setwins_reader_go", 64'(iq_ex_valid), 64'(1));

        // Busy unit 1 holds the head for three cycles
        ex_iq_busy = 3'b010;
        enq(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 2'd1, 48'h0000_0000_0B01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_hold", 64'(iq_ex_valid), 64'(0));
        end
        ex_iq_busy = 3'b000;
        tick();
        check("busy_release", 64'(iq_ex_valid), 64'(1));

        // Invalid unit 3 pops silently and raises the sticky error
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 2'd3, 48'h0000_0000_0BAD, 1'b0);
        tick();
        check("badunit_valid", 64'(iq_ex_valid), 64'(0));
        check("badunit_err",   64'(iq_err_unit), 64'(1));
        check("badunit_count", 64'(iq_count),    64'(0));
        enq(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 48'h0000_0000_0707, 1'b1);
        tick();
        check("badunit_no_pending", 64'(iq_ex_valid), 64'(1));

        // r0 writer never blocks a following r0 reader
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 2'd0, 48'h0000_0000_0000, 1'b1);
        enq(5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 2'd0, 48'h0000_0000_0001, 1'b1);
        check("r0_writer", 64'(iq_ex_valid), 64'(1));
        tick();
        check("r0_reader", 64'(iq_ex_valid), 64'(1));

        // Flush with 3 buffered entries; earlier pending r9 survives
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 2'd0, 48'h0000_0000_0F00, 1'b1);
        tick();
        check("flush_pre_dispatch", 64'(iq_ex_valid), 64'(1));
        ex_iq_busy = 3'b001;
        for (int i = 0; i < 3; i++)
            enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 48'h0000_0000_0F10 + 48'(i), 1'b0);
        check("flush_pre_count", 64'(iq_count), 64'(3));
        ex_iq_busy = 3'b000;
        flush = 1'b1;
        id_iq_valid = 1'b1;
        tick();
        flush = 1'b0;
        id_iq_valid = 1'b0;
        check("flush_count", 64'(iq_count),    64'(0));
        check("flush_valid", 64'(iq_ex_valid), 64'(0));
        tick();
        check("flush_idle_valid", 64'(iq_ex_valid), 64'(0));
        enq(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 48'h0000_0000_0F20, 1'b1);
        tick();
        check("flush_pending_kept", 64'(iq_ex_valid), 64'(0));
        wb(5'd9);
        tick();
        check("flush_pending_release", 64'(iq_ex_valid), 64'(1));

        // Asynchronous reset in the middle of a cycle
        ex_iq_busy = 3'b001;
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd20, 1'b1, 2'd0, 48'h0000_0000_0AA0, 1'b1);
        enq(5'd1, 5'd2, 1'b0, 1'b0, 5'd21, 1'b1, 2'd0, 48'h0000_0000_0AA1, 1'b0);
        ex_iq_busy = 3'b000;
        tick();
        check("prereset_valid", 64'(iq_ex_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check("arst_count",    64'(iq_count),       64'(0));
        check("arst_valid",    64'(iq_ex_valid),    64'(0));
        check("arst_rega",     64'(iq_ex_rega),     64'(0));
        check("arst_ctrl",     64'(iq_ex_ctrl),     64'(0));
        check("arst_regdest",  64'(iq_ex_regdest),  64'(0));
        check("arst_writereg", 64'(iq_ex_writereg), 64'(0));
        check("arst_err",      64'(iq_err_unit),    64'(0));
        check("arst_ready",    64'(iq_id_ready),    64'(1));
        #2;
        reset = 1'b1;
        tick();
        check("postreset_count", 64'(iq_count),    64'(0));
        check("postreset_valid", 64'(iq_ex_valid), 64'(0));
        enq(5'd20, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 48'h0000_0000_0AA2, 1'b1);
        tick();
        check("postreset_pending_clear", 64'(iq_ex_valid), 64'(1));

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
